manchester_encoder: RTL

MANCHESTER_ENCODER -- requirements
Module: manchester_encoder

---
 rtl/manchester_pkg.sv | 28 ++
 rtl/manchester_bit_timer.sv | 47 ++++
 rtl/manchester_encoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/manchester_pkg.sv
// Types and constants shared by the Manchester encode and decode sides.
// The ST_PRE state exists only when MANCH_PREAMBLE_EN is defined.
package manchester_pkg;

  localparam int MANCH_HALF_PERIOD = 8;
  localparam int MANCH_RX_MID      = MANCH_HALF_PERIOD;

`ifdef MANCH_PREAMBLE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } manch_state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } manch_state_e;
`endif

  // Counter width for the larger of two bit counts, never below one bit.
  function automatic int manch_cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Half-bit timer: counts HALF_PERIOD clocks per half and tracks which half of
// the bit is on the line; held at zero while run is low.
module manchester_bit_timer
  import manchester_pkg::*;
#(
  parameter int HALF_PERIOD = MANCH_HALF_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic second_half,
  output logic half_tick,
  output logic bit_tick,
  output logic half_pre_tick
);

  localparam int            CW        = $clog2(HALF_PERIOD);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] HALF_PRE  = CW'(HALF_PERIOD - 2);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    half_tick     = run && (cnt_q == HALF_LAST);
    bit_tick      = half_tick && phase_q;
    half_pre_tick = run && (cnt_q == HALF_PRE);
    second_half   = phase_q;
    cnt_d         = '0;
    phase_d       = 1'b0;
    if (run) begin
      cnt_d   = half_tick ? '0 : cnt_q + CW'(1);
      phase_d = phase_q ^ half_tick;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/manchester_encoder.sv
// Manchester serialiser, LSB first, bit 1 = low/high, bit 0 = high/low.
// Defining MANCH_PREAMBLE_EN prefixes each frame with PRE_BITS bits 1,0,1,0...
module manchester_encoder
  import manchester_pkg::*;
#(
  parameter int HALF_PERIOD = MANCH_HALF_PERIOD,
  parameter int DATA_W      = 8,
  parameter int PRE_BITS    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_en
);

  generate
    if (HALF_PERIOD < 2 || DATA_W < 1) begin : g_bad_param
      $error("manchester_encoder: HALF_PERIOD must be >= 2 and DATA_W >= 1");
    end
  endgenerate

  localparam int            BW        = manch_cnt_w(DATA_W, PRE_BITS);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
`ifdef MANCH_PREAMBLE_EN
  localparam logic [BW-1:0] PRE_LAST  = BW'(PRE_BITS - 1);
  localparam manch_state_e  ST_START  = ST_PRE;
`else
  localparam manch_state_e  ST_START  = ST_DATA;
`endif

  manch_state_e      state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_en_q, tx_en_d;

  logic run;
  logic transfer;
  logic cur_bit;
  logic second_half;
  logic unused_half_tick;
  logic bit_tick;
  logic half_pre_tick;

  assign run = (state_q != ST_IDLE);

  manchester_bit_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .second_half  (second_half),
    .half_tick    (unused_half_tick),
    .bit_tick     (bit_tick),
    .half_pre_tick(half_pre_tick)
  );

  // Outputs are registered from the current position, so the line lags the
  // internal frame by one clock; in_ready is raised one clock ahead of the last.
  always_comb begin
    transfer  = in_valid && in_ready_q;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cur_bit   = shift_q[0];
    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d   = ST_START;
          shift_d   = in_data;
          bit_cnt_d = '0;
        end
      end
`ifdef MANCH_PREAMBLE_EN
      ST_PRE: begin
        cur_bit = ~bit_cnt_q[0];
        if (bit_tick) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
`endif
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            if (transfer) begin
              state_d = ST_START;
              shift_d = in_data;
            end else begin
              state_d = ST_IDLE;
              shift_d = '0;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tx_en_d    = run;
    tx_out_d   = run && (cur_bit ^ ~second_half);
    in_ready_d = (state_d == ST_IDLE) ||
                 ((state_q == ST_DATA) && (bit_cnt_q == DATA_LAST) &&
                  second_half && half_pre_tick);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      in_ready_q <= 1'b0;
      tx_out_q   <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      in_ready_q <= in_ready_d;
      tx_out_q   <= tx_out_d;
      tx_en_q    <= tx_en_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx_out   = tx_out_q;
  assign tx_en    = tx_en_q;

endmodule
